// File: rtl/gpu_text_scanout_if.sv
// rtl/gpu_text_scanout_if.sv - control, framebuffer read port and character stream bundle
interface gpu_text_scanout_if #(
    parameter int ADDR_W = 11,
    parameter int COL_W  = 7,
    parameter int ROW_W  = 5
);
    logic              frame_start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic [ADDR_W-1:0] fb_addr;
    logic [63:0]       fb_data;
    logic [15:0]       char_data;
    logic [COL_W-1:0]  char_col;
    logic [ROW_W-1:0]  char_row;
    logic              char_last;
    logic              char_valid;
    logic              char_ready;

    modport master (
        input  frame_start, base_addr, fb_data, char_ready,
        output busy, fb_addr, char_data, char_col, char_row, char_last, char_valid
    );

    modport slave (
        output frame_start, base_addr, fb_data, char_ready,
        input  busy, fb_addr, char_data, char_col, char_row, char_last, char_valid
    );
endinterface

// File: rtl/gpu_text_scanout.sv
// rtl/gpu_text_scanout.sv - text framebuffer scanout into a one-cell-per-clock character stream
module gpu_text_scanout #(
    parameter int COLUMNS                = 80,
    parameter int ROWS                   = 30,
    parameter int framebufferSize        = 1200,
    parameter int framebufferSizeAddress = 11
) (
    input  logic               clock,
    input  logic               reset_n,
    gpu_text_scanout_if.master bus
);
    localparam int A     = framebufferSizeAddress;
    localparam int WORDS = COLUMNS * ROWS / 4;
    localparam int IDX_W = $clog2(WORDS + 1);
    localparam int COL_W = $clog2(COLUMNS);
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILL   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [1:0]       r_state;
    logic [A-1:0]     r_base;
    logic [IDX_W-1:0] r_word_idx;
    logic [A-1:0]     r_fb_addr;
    logic [63:0]      r_shift;
    logic [1:0]       r_lane;
    logic [63:0]      r_pf_data;
    logic             r_pf_full;
    logic             r_pending;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_valid;
    logic             r_last;
    logic             r_busy;

    logic [A:0]       w_sum;
    logic [A:0]       w_wrapped;
    logic [A-1:0]     w_fetch_addr;
    logic             w_words_left;
    logic             w_accept;
    logic             w_lane_end;
    logic             w_pf_move;
    logic             w_issue;
    logic [COL_W-1:0] w_next_col;
    logic [ROW_W-1:0] w_next_row;
    logic             w_next_last;
    logic [15:0]      w_char_data;

    assign w_sum        = {1'b0, r_base} + {{(A + 1 - IDX_W){1'b0}}, r_word_idx};
    assign w_wrapped    = (w_sum >= (A + 1)'(framebufferSize)) ? w_sum - (A + 1)'(framebufferSize) : w_sum;
    assign w_fetch_addr = w_wrapped[A-1:0];
    assign w_words_left = r_word_idx < IDX_W'(WORDS);

    assign w_accept   = r_valid && bus.char_ready;
    assign w_lane_end = (r_lane == 2'd3);

    // The slot drains either on a lane-3 handoff or when recovering from an underrun.
    assign w_pf_move = (r_state == S_STREAM) && r_pf_full &&
                       ((w_accept && w_lane_end && !r_last) || !r_valid);

    // A single outstanding fetch: only refill a slot that is empty and not already awaiting data.
    assign w_issue = w_words_left &&
                     ((r_state == S_FILL) ||
                      ((r_state == S_STREAM) && ((!r_pf_full && !r_pending) || w_pf_move)));

    assign w_next_col  = (r_col == COL_W'(COLUMNS - 1)) ? '0 : r_col + COL_W'(1);
    assign w_next_row  = (r_col == COL_W'(COLUMNS - 1)) ? r_row + ROW_W'(1) : r_row;
    assign w_next_last = (w_next_col == COL_W'(COLUMNS - 1)) && (w_next_row == ROW_W'(ROWS - 1));

    always_comb begin
        w_char_data = r_shift[15:0];
        case (r_lane)
            2'd0:    w_char_data = r_shift[15:0];
            2'd1:    w_char_data = r_shift[31:16];
            2'd2:    w_char_data = r_shift[47:32];
            default: w_char_data = r_shift[63:48];
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_word_idx <= '0;
            r_fb_addr  <= '0;
            r_shift    <= '0;
            r_lane     <= '0;
            r_pf_data  <= '0;
            r_pf_full  <= 1'b0;
            r_pending  <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_pending <= w_issue;
            if (w_issue) begin
                r_fb_addr  <= w_fetch_addr;
                r_word_idx <= r_word_idx + IDX_W'(1);
            end

            if (r_pending && (r_state == S_STREAM)) begin
                r_pf_data <= bus.fb_data;
                r_pf_full <= 1'b1;
            end else if (w_pf_move) begin
                r_pf_full <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_valid   <= 1'b0;
                    r_pf_full <= 1'b0;
                    if (bus.frame_start) begin
                        r_base     <= bus.base_addr;
                        r_fb_addr  <= bus.base_addr;
                        r_word_idx <= IDX_W'(1);
                        r_busy     <= 1'b1;
                        r_state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_shift <= bus.fb_data;
                    r_lane  <= 2'd0;
                    r_col   <= '0;
                    r_row   <= '0;
                    r_last  <= 1'b0;
                    r_valid <= 1'b1;
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_accept) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_col  <= w_next_col;
                            r_row  <= w_next_row;
                            r_last <= w_next_last;
                            r_lane <= r_lane + 2'd1;
                            if (w_lane_end) begin
                                if (r_pf_full) begin
                                    r_shift <= r_pf_data;
                                end else begin
                                    r_valid <= 1'b0;
                                end
                            end
                        end
                    end else if (!r_valid && r_pf_full) begin
                        r_shift <= r_pf_data;
                        r_valid <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.fb_addr    = r_fb_addr;
    assign bus.char_data  = w_char_data;
    assign bus.char_col   = r_col;
    assign bus.char_row   = r_row;
    assign bus.char_last  = r_last;
    assign bus.char_valid = r_valid;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_gpu_text_scanout.sv
// tb/tb_gpu_text_scanout.sv - randomized scoreboard bench for gpu_text_scanout
module tb_gpu_text_scanout;
    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int FB    = 1200;
    localparam int TOTAL = COLS * ROWS;
    localparam int WORDS = TOTAL / 4;

    logic clock;
    logic reset_n;

    gpu_text_scanout_if #(.ADDR_W(11), .COL_W(7), .ROW_W(5)) bus ();

    gpu_text_scanout #(
        .COLUMNS(COLS), .ROWS(ROWS), .framebufferSize(FB), .framebufferSizeAddress(11)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    logic [63:0] mem [0:2047];
    logic [15:0] got_data [0:TOTAL-1];

    int tests = 0;
    int fails = 0;
    int exp_idx = 0;
    int issued = 0;
    int m_base = 0;
    bit mon_en = 0;
    bit ready_mode = 0;
    bit prev_stall = 0;
    logic [10:0] prev_addr = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [28:0] exp_cell(input int i, input int b);
        int a;
        logic [63:0] w;
        a = (b + i / 4) % FB;
        w = mem[a];
        return {w[16*(i%4) +: 16], 7'(i % COLS), 5'(i / COLS), 1'(i == TOTAL - 1)};
    endfunction

    initial begin
        forever begin
            @(negedge clock);
            bus.fb_data = mem[bus.fb_addr];
        end
    end

    initial begin
        bus.char_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            bus.char_ready = ready_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    // Scoreboard: expected cell order, fetch addresses and outstanding-fetch bound.
    initial begin
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (bus.frame_start && !bus.busy) begin
                    exp_idx    = 0;
                    issued     = 0;
                    prev_stall = 0;
                end else begin
                    if ((issued == 0 && bus.busy) || (issued > 0 && bus.fb_addr != prev_addr)) begin
                        check("fetch_addr", 64'(bus.fb_addr), 64'((m_base + issued) % FB));
                        issued++;
                        prev_addr = bus.fb_addr;
                        check("outstanding", 64'(issued - exp_idx / 4 <= 2), 64'd1);
                    end
                    if (prev_stall)
                        check("stall_hold_valid", 64'(bus.char_valid), 64'd1);
                    if (bus.char_valid) begin
                        if (exp_idx >= TOTAL)
                            check("extra_cell", 64'(exp_idx), 64'(TOTAL - 1));
                        else
                            check("cell", 64'({bus.char_data, bus.char_col, bus.char_row, bus.char_last}),
                                  64'(exp_cell(exp_idx, m_base)));
                    end else if (!ready_mode && exp_idx > 0 && exp_idx < TOTAL) begin
                        check("no_gap_valid", 64'(bus.char_valid), 64'd1);
                    end
                    if (bus.char_valid && bus.char_ready) begin
                        if (exp_idx < TOTAL) got_data[exp_idx] = bus.char_data;
                        exp_idx++;
                    end
                    prev_stall = bus.char_valid && !bus.char_ready;
                end
            end
        end
    end

    task automatic start_frame(input int b);
        @(posedge clock);
        #1;
        mon_en = 1;
        m_base = b;
        bus.base_addr = 11'(b);
        bus.frame_start = 1'b1;
        @(posedge clock);
        #1;
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (bus.busy && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("frame_done_in_budget", 64'(bus.busy), 64'd0);
        check("cells_accepted", 64'(exp_idx), 64'(TOTAL));
        check("words_fetched", 64'(issued), 64'(WORDS));
        check("valid_after_frame", 64'(bus.char_valid), 64'd0);
        mon_en = 0;
    endtask

    task automatic wait_idx(input int target, input int budget);
        int n;
        n = 0;
        while (exp_idx < target && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("reach_cell", 64'(exp_idx >= target), 64'd1);
    endtask

    initial begin
        int n;
        for (int a = 0; a < 2048; a++)
            mem[a] = (a < FB) ? {16'(4*a+3), 16'(4*a+2), 16'(4*a+1), 16'(4*a)}
                              : {$urandom, $urandom};
        reset_n = 1'b0;
        bus.frame_start = 1'b0;
        bus.base_addr = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", 64'({bus.fb_addr, bus.char_data, bus.char_col, bus.char_row,
                                    bus.char_last, bus.char_valid, bus.busy}), 64'd0);
        reset_n = 1'b1;

        // Straight frame, ready always high.
        ready_mode = 0;
        start_frame(0);
        check("busy_after_start", 64'(bus.busy), 64'd1);
        wait_done(3000, n);
        check("last_accept_edge", 64'(n), 64'd2401);
        check("first_cell", 64'(got_data[0]), 64'd0);
        check("final_cell", 64'(got_data[TOTAL-1]), 64'd2399);

        // Address wrap at the framebuffer end.
        start_frame(1100);
        wait_done(3000, n);
        check("wrap_cell_0_0", 64'(got_data[0]), 64'd4400);
        check("wrap_cell_79_4", 64'(got_data[399]), 64'd4799);
        check("wrap_cell_0_5", 64'(got_data[400]), 64'd0);

        // Random backpressure.
        ready_mode = 1;
        start_frame(0);
        wait_done(30000, n);
        check("bp_mid_cell", 64'(got_data[1234]), 64'd1234);
        ready_mode = 0;

        // frame_start and base_addr change mid-frame must be ignored.
        start_frame(300);
        wait_idx(500, 3000);
        @(posedge clock);
        #1;
        bus.frame_start = 1'b1;
        bus.base_addr = 11'd777;
        @(posedge clock);
        #1;
        bus.frame_start = 1'b0;
        check("busy_during_holdoff", 64'(bus.busy), 64'd1);
        wait_done(3000, n);
        check("holdoff_first_cell", 64'(got_data[0]), 64'd1200);

        // Asynchronous reset mid-frame.
        start_frame(50);
        wait_idx(1000, 3000);
        @(posedge clock);
        #3;
        mon_en = 0;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({bus.fb_addr, bus.char_data, bus.char_col, bus.char_row,
                                          bus.char_last, bus.char_valid, bus.busy}), 64'd0);
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("idle_after_reset", 64'({bus.char_valid, bus.busy}), 64'd0);
        start_frame(200);
        wait_done(3000, n);
        check("restart_edge", 64'(n), 64'd2401);
        check("restart_cell_0_0", 64'(got_data[0]), 64'd800);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gpu_text_scanout.md
# gpu_text_scanout

Reads the text-mode framebuffer and turns it into a character stream for the glyph renderer. Each 64-bit framebuffer word holds four 16-bit character cells. On each frame start the block walks the 80×30 grid, 600 words, in raster order. It issues read addresses to the framebuffer's read port and unpacks each word into one cell per handshake. A one-word prefetch buffer sustains one character per clock while the renderer is ready.

## Interface
Parameters:
- COLUMNS, 80, characters per row (multiple of 4)
- ROWS, 30, character rows per frame
- framebufferSize, 1200, framebuffer depth in 64-bit words (address wrap point)
- framebufferSizeAddress, 11, framebuffer address width

Ports:
- clock  in  1  system clock; all state changes on posedge
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  single-cycle pulse; starts a frame scan
- base_addr  in  11  word address of cell (0,0); latched on an accepted frame_start
- fb_addr  out  11  framebuffer read address, registered
- fb_data  in  64  framebuffer read data; valid one posedge after fb_addr changes
- char_data  out  16  cell contents: [7:0] code, [15:8] attribute
- char_col  out  7  column of char_data
- char_row  out  5  row of char_data
- char_last  out  1  high with the final cell (COLUMNS-1, ROWS-1)
- char_valid  out  1  char_* outputs valid
- char_ready  in  1  renderer accepts the cell when char_valid && char_ready
- busy  out  1  high from an accepted frame_start until the last cell is accepted

## Operation
- Reset values: fb_addr=0, char_data=0, char_col=0, char_row=0, char_last=0, char_valid=0, busy=0. The FSM goes to IDLE and both word buffers are marked empty.
- FSM states:
  - IDLE: frame_start latches base_addr, drives fb_addr=base_addr, sets word index to 0, goes to FILL.
  - FILL: captures fb_data into the shift register and sets lane=0. Issues the next word address into the prefetch slot, then goes to STREAM.
  - STREAM: emits cells as they are handshaken; details below.
  - Return to IDLE when the cell with char_last is accepted.
- Lane order: cell k uses fb_data[16k+15:16k], so lane 0 (bits [15:0]) goes out first.
- Addressing: word n is read at (base_addr + n). If the sum is ≥ framebufferSize, subtract framebufferSize (wrap to 0). Word indices run 0..(COLUMNS×ROWS/4 − 1).
- Prefetch: one fetch is outstanding at most. The next fetch is issued (fb_addr updated) only when the prefetch slot is empty or being emptied this cycle, and words remain. The word returns one cycle later and is written into the slot. fb_addr holds its last value otherwise.
- STREAM behaviour:
  - On each accept, lane increments and char_col increments.
  - At col = COLUMNS−1, col wraps to 0 and row increments.
  - When lane 3 is accepted and the prefetch slot is full, the prefetch word moves into the shift register with no bubble.
  - If the slot is empty, char_valid drops until the word arrives.
- char_valid && !char_ready: all char_* outputs hold stable.
- frame_start while busy is ignored.
- base_addr changes after latching have no effect on the current frame.
- reset_n low mid-frame aborts immediately to reset values. The next frame_start after release starts cleanly.

## Timing
- Edge E samples frame_start. fb_addr = base_addr after E.
- E+1: word 0 captured. char_valid=1 and cell (0,0) presented. fb_addr = base_addr+1.
- E+2: prefetch captures word 1.
- With char_ready held high, cells are accepted at E+2, E+3, … with no gaps. The last cell is accepted at E+2401, then busy=0 and char_valid=0 after that edge.
- The framebuffer samples fb_addr on negedge and updates its output on negedge. fb_addr must change only on posedge.
- Throughput is one cell/cycle sustained. Backpressure only stalls the stream and loses no data.

## Test plan
- Reset, base_addr=0, frame_start, char_ready=1:
  - Word n has cells {4n+3, 4n+2, 4n+1, 4n} (16-bit each, lane 0 = 4n).
  - Required: 2400 cells in order 0..2399, no valid gaps, char_last only on cell 2399 with col=79, row=29; busy drops the cycle after.
- Wrap: base_addr=1100:
  - fb_addr sequence 1100..1199, then 0..499.
  - Cell (0,0) comes from word 1100; cell at col 0, row 5 comes from word 0.
- Backpressure: char_ready toggled pseudo-randomly (≈30% high):
  - Stream identical to the first test.
  - char_data/col/row stable while valid && !ready; never more than one fetch outstanding.
- Holdoff: frame_start pulsed at cell 500 and base_addr changed mid-frame:
  - Both ignored; the frame completes unaltered from the original base.
- Reset mid-frame: reset_n low at cell 1000 for 2 cycles, asynchronously:
  - All outputs go to reset values immediately.
  - A new frame_start with base_addr=200 starts at word 200, cell (0,0).
- Line boundary:
  - Cells at col 79→0 increment row exactly once.
  - char_col never reaches 80.
